sdram_init_refresh_ctrl: RTL

- Parametrised SDRAM bring-up and refresh engine for the W9825G6KH class of single-data-rate SDRAM.
- Drives the power-up sequence: pause, PRECHARGE-ALL, N x AUTO-REFRESH, then MODE REGISTER SET.
- After init, it schedules periodic AUTO-REFRESH through a request/grant handshake with the future read/write engine.
- Owns the command bus during init and during granted refreshes. The read/write engine muxes on bus_own.

---
 rtl/sdram_pkg.sv | 45 ++++
 rtl/sdram_init_refresh_ctrl_if.sv | 34 +++
 rtl/sdram_ref_timer.sv | 37 +++
 rtl/sdram_init_refresh_ctrl.sv | 119 +++++++++++
 4 files changed

// File: rtl/sdram_pkg.sv
// Shared SDRAM command encodings, mode-register layout and W9825G6KH timing defaults (100 MHz).
// Imported by the init/refresh engine and the read/write engine.
package sdram_pkg;

  localparam logic [3:0] CMD_INHIBIT = 4'b1111;
  localparam logic [3:0] CMD_NOP     = 4'b0111;
  localparam logic [3:0] CMD_ACT     = 4'b0011;
  localparam logic [3:0] CMD_RD      = 4'b0101;
  localparam logic [3:0] CMD_WR      = 4'b0100;
  localparam logic [3:0] CMD_PRE     = 4'b0010;
  localparam logic [3:0] CMD_AREF    = 4'b0001;
  localparam logic [3:0] CMD_MRS     = 4'b0000;

  localparam int MR_BL_LSB = 0;
  localparam int MR_BT_BIT = 3;
  localparam int MR_CL_LSB = 4;
  localparam int MR_WB_BIT = 9;
  localparam int A_AP_BIT  = 10;

  localparam int DEF_T_INIT       = 20000;
  localparam int DEF_T_RP         = 2;
  localparam int DEF_T_RC         = 7;
  localparam int DEF_T_MRD        = 2;
  localparam int DEF_INIT_AREF    = 8;
  localparam int DEF_REF_INTERVAL = 781;

  typedef enum logic [3:0] {
    S_WAIT, S_PRE, S_PRE_W, S_AREF, S_AREF_W,
    S_MRS, S_MRS_W, S_IDLE, S_REF, S_REF_W
  } init_state_t;

  function automatic logic [15:0] mode_reg(input int cas_lat, input logic [2:0] burst_code,
                                           input logic burst_type, input logic wb_single);
    logic [15:0] mr;
    logic [31:0] cl;
    cl = cas_lat;
    mr = '0;
    mr[MR_BL_LSB +: 3] = burst_code;
    mr[MR_BT_BIT]      = burst_type;
    mr[MR_CL_LSB +: 3] = cl[2:0];
    mr[MR_WB_BIT]      = wb_single;
    return mr;
  endfunction

endpackage

// File: rtl/sdram_init_refresh_ctrl_if.sv
// SDRAM command bus plus the refresh request/grant handshake with the read/write engine.
// master = init/refresh engine, slave = the side that grants refreshes and observes the bus.
interface sdram_init_refresh_ctrl_if #(
  parameter int ADDR_W = 13,
  parameter int BA_W   = 2,
  parameter int DQM_W  = 2
);
  logic              CKE;
  logic              CS_N;
  logic              RAS_N;
  logic              CAS_N;
  logic              WE_N;
  logic [ADDR_W-1:0] A;
  logic [BA_W-1:0]   BS;
  logic [DQM_W-1:0]  DQM;
  logic              init_done;
  logic              ref_req;
  logic              ref_done;
  logic              bus_own;
  logic              ref_miss;
  logic              ref_grant;

  modport master (
    output CKE, CS_N, RAS_N, CAS_N, WE_N, A, BS, DQM,
    output init_done, ref_req, ref_done, bus_own, ref_miss,
    input  ref_grant
  );

  modport slave (
    input  CKE, CS_N, RAS_N, CAS_N, WE_N, A, BS, DQM,
    input  init_done, ref_req, ref_done, bus_own, ref_miss,
    output ref_grant
  );
endinterface

// File: rtl/sdram_ref_timer.sv
// Refresh interval timer: raises ref_req every REF_INTERVAL clocks, flags ref_miss if one is still pending.
// Latency: registered, 1 cycle; a request is held until grant takes it, never queued twice.
module sdram_ref_timer #(
  parameter int REF_INTERVAL = 781
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable,
  input  logic reload,
  input  logic grant,
  output logic ref_req,
  output logic ref_miss
);
  localparam int TW = $clog2(REF_INTERVAL + 1);

  logic [TW-1:0] tmr;
  logic          expire;
  logic          take;

  assign expire = enable && (tmr == TW'(REF_INTERVAL - 1));
  assign take   = grant && ref_req;

  // An AREF issued on the expiry cycle wins: request drops, no miss recorded.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmr      <= '0;
      ref_req  <= 1'b0;
      ref_miss <= 1'b0;
    end else begin
      if (!enable || reload || expire) tmr <= '0;
      else                             tmr <= tmr + 1'b1;
      if (take)        ref_req <= 1'b0;
      else if (expire) ref_req <= 1'b1;
      if (expire && ref_req && !take) ref_miss <= 1'b1;
    end
  end
endmodule

// File: rtl/sdram_init_refresh_ctrl.sv
// SDRAM power-up sequence (pause, PRE-all, N x AREF, MRS) then periodic AREF via ref_req/ref_grant.
// Latency: all outputs registered from the next state; refresh waits indefinitely for ref_grant.
module sdram_init_refresh_ctrl
  import sdram_pkg::*;
#(
  parameter int         T_INIT       = DEF_T_INIT,
  parameter int         T_RP         = DEF_T_RP,
  parameter int         T_RC         = DEF_T_RC,
  parameter int         T_MRD        = DEF_T_MRD,
  parameter int         INIT_AREF    = DEF_INIT_AREF,
  parameter int         REF_INTERVAL = DEF_REF_INTERVAL,
  parameter int         CAS_LAT      = 3,
  parameter logic [2:0] BURST_CODE   = 3'b011,
  parameter logic       BURST_TYPE   = 1'b0,
  parameter logic       WB_SINGLE    = 1'b0,
  parameter int         ADDR_W       = 13,
  parameter int         BA_W         = 2,
  parameter int         DQM_W        = 2
) (
  input logic                       REF_CLK,
  input logic                       RST_N,
  sdram_init_refresh_ctrl_if.master sdram
);
  localparam int                CNT_W   = $clog2(T_INIT + T_RP + T_RC + T_MRD + 1);
  localparam logic [15:0]       MR_FULL = mode_reg(CAS_LAT, BURST_CODE, BURST_TYPE, WB_SINGLE);
  localparam logic [ADDR_W-1:0] MR_VAL  = MR_FULL[ADDR_W-1:0];
  localparam logic [ADDR_W-1:0] PRE_ALL = ADDR_W'(1) << A_AP_BIT;

  init_state_t       state, state_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic [3:0]        aref_cnt;
  logic [3:0]        cmd_q, cmd_nxt;
  logic [ADDR_W-1:0] a_q, a_nxt;
  logic [DQM_W-1:0]  dqm_q;
  logic              cke_q, init_done_q, init_done_nxt, ref_done_q, bus_own_q;
  logic              ref_req, ref_miss;

  always_comb begin
    state_nxt = state;
    case (state)
      S_WAIT:   if (cnt == CNT_W'(T_INIT - 1)) state_nxt = S_PRE;
      S_PRE:    state_nxt = S_PRE_W;
      S_PRE_W:  if (cnt == CNT_W'(T_RP - 1)) state_nxt = S_AREF;
      S_AREF:   state_nxt = S_AREF_W;
      S_AREF_W: if (cnt == CNT_W'(T_RC - 1))
                  state_nxt = (aref_cnt < 4'(INIT_AREF)) ? S_AREF : S_MRS;
      S_MRS:    state_nxt = S_MRS_W;
      S_MRS_W:  if (cnt == CNT_W'(T_MRD - 1)) state_nxt = S_IDLE;
      S_IDLE:   if (ref_req && sdram.ref_grant) state_nxt = S_REF;
      S_REF:    state_nxt = S_REF_W;
      S_REF_W:  if (cnt == CNT_W'(T_RC - 1)) state_nxt = S_IDLE;
      default:  state_nxt = S_WAIT;
    endcase

    // The counter runs across a command and its wait state, so a wait ending at T_x-1
    // leaves exactly T_x cycles between consecutive commands.
    cnt_nxt = (state_nxt inside {S_PRE, S_AREF, S_MRS, S_REF, S_IDLE}) ? '0 : cnt + 1'b1;

    cmd_nxt = CMD_NOP;
    a_nxt   = '0;
    case (state_nxt)
      S_PRE:         begin cmd_nxt = CMD_PRE; a_nxt = PRE_ALL; end
      S_AREF, S_REF: cmd_nxt = CMD_AREF;
      S_MRS:         begin cmd_nxt = CMD_MRS; a_nxt = MR_VAL; end
      default:       ;
    endcase

    init_done_nxt = init_done_q || (state_nxt == S_IDLE);
  end

  always_ff @(posedge REF_CLK or negedge RST_N) begin
    if (!RST_N) begin
      state       <= S_WAIT;
      cnt         <= '0;
      aref_cnt    <= '0;
      cke_q       <= 1'b0;
      cmd_q       <= CMD_INHIBIT;
      a_q         <= '0;
      dqm_q       <= '1;
      init_done_q <= 1'b0;
      ref_done_q  <= 1'b0;
      bus_own_q   <= 1'b1;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      if (state == S_AREF) aref_cnt <= aref_cnt + 1'b1;
      cke_q       <= 1'b1;
      cmd_q       <= cmd_nxt;
      a_q         <= a_nxt;
      dqm_q       <= init_done_nxt ? '0 : '1;
      init_done_q <= init_done_nxt;
      ref_done_q  <= (state_nxt == S_REF_W) && (cnt_nxt == CNT_W'(T_RC - 1));
      bus_own_q   <= (state_nxt != S_IDLE);
    end
  end

  sdram_ref_timer #(
    .REF_INTERVAL(REF_INTERVAL)
  ) u_ref_timer (
    .clk      (REF_CLK),
    .rst_n    (RST_N),
    .enable   (init_done_q),
    .reload   (state_nxt == S_REF),
    .grant    ((state == S_IDLE) && sdram.ref_grant),
    .ref_req  (ref_req),
    .ref_miss (ref_miss)
  );

  assign sdram.CKE                                  = cke_q;
  assign {sdram.CS_N, sdram.RAS_N, sdram.CAS_N, sdram.WE_N} = cmd_q;
  assign sdram.A                                    = a_q;
  assign sdram.BS                                   = '0;
  assign sdram.DQM                                  = dqm_q;
  assign sdram.init_done                            = init_done_q;
  assign sdram.ref_req                              = ref_req;
  assign sdram.ref_done                             = ref_done_q;
  assign sdram.bus_own                              = bus_own_q;
  assign sdram.ref_miss                             = ref_miss;
endmodule
